pe_array_sched: RTL and testbench

Front-end scheduler for a row of `PE_NUM` PEs. It buffers the incoming sample stream into gap-free bursts of `LOAD_NUM` words and dispatches one burst to each PE in index order; each PE's load phase requires unbroken `din_pe_v`. It then merges the PEs' `dout_pe` streams into one tagged output stream and reports completion. It sits between the array input port and the `pe` instances.

---
 rtl/pe_array_sched.sv | 217 +++++++++++++++++++++
 tb/tb_pe_array_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_array_sched.sv
// pe_array_sched: front-end scheduler for a row of PE_NUM PEs.
// Buffers the input stream into gap-free LOAD_NUM-word bursts, issues one
// burst per PE in index order, then merges the PE output streams into one
// tagged stream and pulses done after the last word.
// Optional feature macro: PE_SCHED_TIMEOUT_EN enables the COLLECT watchdog.

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef LOAD_NUM
`define LOAD_NUM 4
`endif
`ifndef OUT_NUM
`define OUT_NUM 2
`endif

module pe_array_sched #(
    parameter int PE_NUM   = 4,
    parameter int LOAD_NUM = `LOAD_NUM,
    parameter int OUT_NUM  = `OUT_NUM,
    parameter int TIMEOUT  = 1023,
    localparam int W       = `DATA_WIDTH * 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [W-1:0]        s_data,
    output logic [PE_NUM-1:0]   pe_din_v,
    output logic [W-1:0]        pe_din,
    input  logic [PE_NUM-1:0]   pe_dout_v,
    input  logic [PE_NUM*W-1:0] pe_dout,
    output logic                m_valid,
    output logic [W-1:0]        m_data,
    output logic [3:0]          m_pe_id,
    output logic                done,
    output logic                err
);

    localparam int PW    = (LOAD_NUM > 1) ? $clog2(LOAD_NUM) : 1;
    localparam int PEW   = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
    localparam int TOTAL = OUT_NUM * PE_NUM;
    localparam int OW    = $clog2(TOTAL + 1);

    // Reject configurations outside the supported range at elaboration.
    if (PE_NUM < 2 || PE_NUM > 16 || LOAD_NUM < 1 || LOAD_NUM > 64 ||
        OUT_NUM < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("pe_array_sched: unsupported parameter set");
    end

    typedef enum logic [1:0] {IDLE, FILL, ISSUE, COLLECT} state_t;

    state_t          state;
    logic [W-1:0]    buffer [LOAD_NUM];
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic [PEW-1:0]  pe;
    logic [OW-1:0]   ocnt;
`ifdef PE_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   wdog;
`endif

    logic            accept;
    logic            last_word;
    logic [PW-1:0]   wr_idx;
    logic            any_out;
    logic            multi_out;
    logic [3:0]      sel_id;
    logic [W-1:0]    sel_data;

    // Input is accepted only while the buffer is being filled.
    assign s_ready   = (state == IDLE) || (state == FILL);
    assign accept    = s_valid && s_ready;
    assign wr_idx    = (state == IDLE) ? '0 : wp;
    assign last_word = (state == IDLE) ? (LOAD_NUM == 1) : (wp == PW'(LOAD_NUM - 1));
    assign any_out   = |pe_dout_v;
    assign multi_out = |(pe_dout_v & (pe_dout_v - PE_NUM'(1)));

    // Lowest-index PE with valid output wins the merged stream.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        sel_id   = '0;
        sel_data = pe_dout[W-1:0];
        for (int i = PE_NUM - 1; i >= 0; i--) begin
            if (pe_dout_v[i]) begin
                sel_id   = 4'(i);
                sel_data = pe_dout[i*W +: W];
            end
        end
    end

    // Sample buffer write port.
    // NOTE: the buffer is deliberately not reset; every entry is written
    // before it is read, so a reset would only cost a wide reset tree.
    always_ff @(posedge clk) begin
        if (accept) begin
            buffer[wr_idx] <= s_data;
        end
    end

    // Scheduler FSM with registered load, merge, done and error outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state    <= IDLE;
            wp       <= '0;
            rp       <= '0;
            pe       <= '0;
            ocnt     <= '0;
            pe_din_v <= '0;
            pe_din   <= '0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            m_pe_id  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef PE_SCHED_TIMEOUT_EN
            wdog     <= '0;
`endif
        end else begin
            m_valid <= 1'b0;
            done    <= 1'b0;
            if (state != COLLECT && any_out) begin
                err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        pe <= '0;
                        if (last_word) begin
                            state    <= ISSUE;
                            rp       <= '0;
                            pe_din_v <= PE_NUM'(1);
                            pe_din   <= s_data;
                        end else begin
                            wp    <= PW'(1);
                            state <= FILL;
                        end
                    end
                end

                FILL: begin
                    if (accept) begin
                        if (last_word) begin
                            // First beat goes out on the edge that lands the last word.
                            state    <= ISSUE;
                            rp       <= '0;
                            pe_din_v <= PE_NUM'(1) << pe;
                            pe_din   <= (wp == '0) ? s_data : buffer[0];
                        end else begin
                            wp <= wp + PW'(1);
                        end
                    end
                end

                ISSUE: begin
                    if (rp == PW'(LOAD_NUM - 1)) begin
                        pe_din_v <= '0;
                        pe_din   <= '0;
                        if (pe == PEW'(PE_NUM - 1)) begin
                            state <= COLLECT;
                            ocnt  <= '0;
`ifdef PE_SCHED_TIMEOUT_EN
                            wdog  <= '0;
`endif
                        end else begin
                            pe    <= pe + PEW'(1);
                            wp    <= '0;
                            state <= FILL;
                        end
                    end else begin
                        rp     <= rp + PW'(1);
                        pe_din <= buffer[rp + PW'(1)];
                    end
                end

                COLLECT: begin
                    if (ocnt == OW'(TOTAL)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                        if (any_out) begin
                            err <= 1'b1;
                        end
                    end else begin
                        if (any_out) begin
                            m_valid <= 1'b1;
                            m_data  <= sel_data;
                            m_pe_id <= sel_id;
                            ocnt    <= ocnt + OW'(1);
                            if (multi_out) begin
                                err <= 1'b1;
                            end
                        end
`ifdef PE_SCHED_TIMEOUT_EN
                        if (any_out) begin
                            wdog <= '0;
                        end else if (wdog == TW'(TIMEOUT - 1)) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            wdog <= wdog + TW'(1);
                        end
`endif
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_array_sched.sv
// Directed self-checking bench for pe_array_sched with PE_NUM=2,
// LOAD_NUM=4, OUT_NUM=2 (and TIMEOUT=16 when the watchdog is built in).

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_pe_array_sched;

    localparam int W    = `DATA_WIDTH * 2;
    localparam int PEN  = 2;
    localparam int LOAD = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [W-1:0]     s_data;
    logic [PEN-1:0]   pe_din_v;
    logic [W-1:0]     pe_din;
    logic [PEN-1:0]   pe_dout_v;
    logic [PEN*W-1:0] pe_dout;
    logic             m_valid;
    logic [W-1:0]     m_data;
    logic [3:0]       m_pe_id;
    logic             done;
    logic             err;

    int tests = 0;
    int fails = 0;

    pe_array_sched #(
        .PE_NUM  (PEN),
        .LOAD_NUM(LOAD),
        .OUT_NUM (2),
        .TIMEOUT (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .pe_din_v (pe_din_v),
        .pe_din   (pe_din),
        .pe_dout_v(pe_dout_v),
        .pe_dout  (pe_dout),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_pe_id  (m_pe_id),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "time limit");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Feed LOAD words base..base+LOAD-1, optionally with an idle cycle between words.
    task automatic feed_burst(input int base, input bit gappy);
        for (int i = 0; i < LOAD; i++) begin
            s_valid = 1'b1;
            s_data  = W'(base + i);
            check("fill_ready", s_ready, 1);
            tick;
            if (i != LOAD - 1) begin
                check("fill_no_din", pe_din_v, 0);
                if (gappy) begin
                    s_valid = 1'b0;
                    s_data  = '1;
                    tick;
                    check("gap_ready", s_ready, 1);
                    check("gap_no_din", pe_din_v, 0);
                end
            end
        end
        s_valid = 1'b0;
    endtask

    // Expect LOAD consecutive beats to PE p; offered input during ISSUE must be refused.
    task automatic expect_burst(input int p, input int base);
        for (int j = 0; j < LOAD; j++) begin
            s_valid = 1'b1;
            s_data  = W'(32'h0DEA_0000 + j);
            check("burst_v", pe_din_v, 64'(1) << p);
            check("burst_d", pe_din, base + j);
            check("issue_ready", s_ready, 0);
            tick;
        end
        s_valid = 1'b0;
        check("post_burst_v", pe_din_v, 0);
    endtask

    task automatic load_all(input bit gappy);
        for (int p = 0; p < PEN; p++) begin
            feed_burst(p * LOAD, gappy);
            expect_burst(p, p * LOAD);
        end
    endtask

    task automatic out_step(input logic [1:0] v, input logic [W-1:0] d0, input logic [W-1:0] d1,
                            input logic [3:0] exp_id, input logic [W-1:0] exp_d);
        pe_dout_v = v;
        pe_dout   = {d1, d0};
        tick;
        check("m_valid", m_valid, 1);
        check("m_data", m_data, exp_d);
        check("m_pe_id", m_pe_id, exp_id);
        check("done_early", done, 0);
    endtask

    task automatic expect_done(input logic exp_err);
        pe_dout_v = '0;
        tick;
        check("final_m_valid", m_valid, 0);
        check("done_pulse", done, 1);
        check("done_err", err, exp_err);
        tick;
        check("done_clear", done, 0);
        check("idle_ready", s_ready, 1);
        check("idle_err", err, exp_err);
    endtask

    initial begin
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        pe_dout_v = '0;
        pe_dout   = '0;
        tick;
        tick;
        check("rst_din_v", pe_din_v, 0);
        check("rst_din", pe_din, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_pe_id", m_pe_id, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        tick;
        check("rst_ready", s_ready, 1);

        // Contiguous load 0..7, then PE0 emits A,B and PE1 emits C,D.
        load_all(1'b0);
        out_step(2'b01, 32'hA0A0_000A, 32'h0, 4'd0, 32'hA0A0_000A);
        pe_dout_v = '0;
        tick;
        check("collect_gap_valid", m_valid, 0);
        out_step(2'b01, 32'hB0B0_000B, 32'h0, 4'd0, 32'hB0B0_000B);
        out_step(2'b10, 32'h0, 32'hC0C0_000C, 4'd1, 32'hC0C0_000C);
        out_step(2'b10, 32'h0, 32'hD0D0_000D, 4'd1, 32'hD0D0_000D);
        expect_done(1'b0);

        // Gappy load; colliding outputs drop PE1's word and set sticky err.
        load_all(1'b1);
        out_step(2'b11, 32'hE0E0_000E, 32'hF0F0_000F, 4'd0, 32'hE0E0_000E);
        check("collide_err", err, 1);
        out_step(2'b01, 32'h1111_0001, 32'h0, 4'd0, 32'h1111_0001);
        out_step(2'b10, 32'h0, 32'h2222_0002, 4'd1, 32'h2222_0002);
        out_step(2'b10, 32'h0, 32'h3333_0003, 4'd1, 32'h3333_0003);
        check("sticky_err", err, 1);
        expect_done(1'b1);

        // Reset during the second ISSUE beat abandons the burst.
        feed_burst(0, 1'b0);
        check("abort_beat0_v", pe_din_v, 1);
        check("abort_beat0_d", pe_din, 0);
        tick;
        check("abort_beat1_v", pe_din_v, 1);
        check("abort_beat1_d", pe_din, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort_din_v", pe_din_v, 0);
        check("abort_ready", s_ready, 1);
        check("abort_err", err, 0);
        check("abort_m_valid", m_valid, 0);
        load_all(1'b0);
        out_step(2'b01, 32'h4444_0004, 32'h0, 4'd0, 32'h4444_0004);
        out_step(2'b01, 32'h5555_0005, 32'h0, 4'd0, 32'h5555_0005);
        out_step(2'b10, 32'h0, 32'h6666_0006, 4'd1, 32'h6666_0006);
        out_step(2'b10, 32'h0, 32'h7777_0007, 4'd1, 32'h7777_0007);
        expect_done(1'b0);

`ifdef PE_SCHED_TIMEOUT_EN
        // No PE output: watchdog fires 16 cycles after COLLECT entry.
        load_all(1'b0);
        for (int k = 1; k < 16; k++) begin
            tick;
            check("wdog_wait_done", done, 0);
            check("wdog_wait_err", err, 0);
        end
        tick;
        check("wdog_done", done, 1);
        check("wdog_err", err, 1);
        tick;
        check("wdog_done_clear", done, 0);
        check("wdog_idle_ready", s_ready, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
